// File: rtl/pmp_checker.sv
// pmp_checker: PMP CSR file (pmpcfg/pmpaddr) plus a one-entry-per-cycle
// address checker that stops at the lowest matching entry.
// Ports:
//   clk, rst (async, active-low)
//   CSR side : addr, wr, write_mode, din -> dout, illegal_address
//   check req: chk_valid/chk_ready, chk_addr, chk_acc {X,W,R}, chk_priv
//   result   : res_valid pulse, res_fault, res_hit, res_entry
// Config: define PMP_NAPOT_EN to enable NA4/NAPOT matching; otherwise
//   A=2/3 writes are stored as OFF and only TOR is matched.
package pmp_pkg;
   typedef enum logic [1:0] {
      CSR_WRITE = 2'd0,
      CSR_SET   = 2'd1,
      CSR_CLEAR = 2'd2
   } write_mode_t;
endpackage

module pmp_checker
   import pmp_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [11:0]      addr,
   input  logic             wr,
   input  write_mode_t      write_mode,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   output logic             illegal_address,
   input  logic             chk_valid,
   output logic             chk_ready,
   input  logic [31:0]      chk_addr,
   input  logic [2:0]       chk_acc,
   input  logic [1:0]       chk_priv,
   output logic             res_valid,
   output logic             res_fault,
   output logic             res_hit,
   output logic [IDX_W-1:0] res_entry
);
   localparam logic [4:0] NCFG = 5'(NUM_ENTRIES / 4);
   localparam logic [4:0] NENT = 5'(NUM_ENTRIES);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ENTRIES - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   logic [NUM_ENTRIES-1:0][7:0]  cfg_q, cfg_d;
   logic [NUM_ENTRIES-1:0][31:0] pa_q, pa_d;
   state_t           state_q, state_d;
   logic [IDX_W-1:0] k_q, k_d;
   logic [31:0]      a_q, a_d;
   logic [2:0]       acc_q, acc_d;
   logic             m_q, m_d;
   logic             fault_q, fault_d;
   logic             hit_q, hit_d;
   logic [IDX_W-1:0] ent_q, ent_d;

   logic [3:0]  sel;
   logic        is_cfg, is_pa, csr_wr;
   logic [31:0] rdata, wdata;
   logic [NUM_ENTRIES-1:0] lck, tor_lck, pa_lck;
   logic [7:0]  ccfg;
   logic [31:0] cur, prv;
   logic        hit, perm_ok, fault_m;
   logic        unused_chk;
`ifdef PMP_NAPOT_EN
   logic [31:0] nmask;
`endif

   // byte offset within the word is irrelevant to word-granular PMP
   assign unused_chk = ^chk_addr[1:0];

   assign sel    = addr[3:0];
   assign is_cfg = (addr[11:4] == 8'h3A) && ({1'b0, sel} < NCFG);
   assign is_pa  = (addr[11:4] == 8'h3B) && ({1'b0, sel} < NENT);
   assign illegal_address = !(is_cfg || is_pa);
   assign csr_wr = wr && !illegal_address;

   always_comb begin
      lck     = '0;
      tor_lck = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         lck[i]     = cfg_q[i][7];
         tor_lck[i] = cfg_q[i][7] && (cfg_q[i][4:3] == 2'b01);
      end
   end

   // a locked TOR entry also protects the base held in the entry below
   assign pa_lck = lck | (tor_lck >> 1);

   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (is_cfg && sel == 4'(i / 4))
            rdata[8*(i%4) +: 8] = cfg_q[i];
         if (is_pa && sel == 4'(i))
            rdata = pa_q[i];
      end
   end
   assign dout = rdata;

   always_comb begin
      case (write_mode)
         CSR_SET:   wdata = rdata | din;
         CSR_CLEAR: wdata = rdata & ~din;
         default:   wdata = din;
      endcase
   end

   function automatic logic [7:0] legal(input logic [7:0] b);
      logic [7:0] r;
      r = b;
      r[6:5] = 2'b00;
      if (r[1] && !r[0])
         r[1] = 1'b0;
`ifndef PMP_NAPOT_EN
      if (r[4])
         r[4:3] = 2'b00;
`endif
      return r;
   endfunction

   always_comb begin
      cfg_d = cfg_q;
      pa_d  = pa_q;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (csr_wr && is_cfg && sel == 4'(i / 4) && !lck[i])
            cfg_d[i] = legal(wdata[8*(i%4) +: 8]);
         if (csr_wr && is_pa && sel == 4'(i) && !pa_lck[i])
            pa_d[i] = wdata;
      end
   end

   always_comb begin
      ccfg = cfg_q[k_q];
      cur  = pa_q[k_q];
      prv  = (k_q == '0) ? '0 : pa_q[k_q - 1'b1];
      hit  = 1'b0;
`ifdef PMP_NAPOT_EN
      // ones at the trailing-ones run plus the next bit: the size field
      nmask = cur ^ (cur + 32'd1);
`endif
      case (ccfg[4:3])
         2'b01: hit = (a_q >= prv) && (a_q < cur);
`ifdef PMP_NAPOT_EN
         2'b10: hit = (a_q == cur);
         2'b11: hit = ((a_q ^ cur) & ~nmask) == '0;
`endif
         default: hit = 1'b0;
      endcase
      perm_ok = |(ccfg[2:0] & acc_q);
      fault_m = !perm_ok && !(m_q && !ccfg[7]);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      a_d     = a_q;
      acc_d   = acc_q;
      m_d     = m_q;
      fault_d = fault_q;
      hit_d   = hit_q;
      ent_d   = ent_q;
      unique case (state_q)
         IDLE: begin
            if (chk_valid) begin
               state_d = SCAN;
               k_d     = '0;
               a_d     = {2'b00, chk_addr[31:2]};
               acc_d   = chk_acc;
               m_d     = (chk_priv == 2'b11);
            end
         end
         SCAN: begin
            // any CSR update invalidates entries already passed
            if (csr_wr) begin
               k_d = '0;
            end else if (hit) begin
               state_d = DONE;
               fault_d = fault_m;
               hit_d   = 1'b1;
               ent_d   = k_q;
            end else if (k_q == LAST) begin
               state_d = DONE;
               fault_d = !m_q;
               hit_d   = 1'b0;
               ent_d   = '0;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_q   <= '0;
         pa_q    <= '0;
         state_q <= IDLE;
         k_q     <= '0;
         a_q     <= '0;
         acc_q   <= '0;
         m_q     <= 1'b0;
         fault_q <= 1'b0;
         hit_q   <= 1'b0;
         ent_q   <= '0;
      end else begin
         cfg_q   <= cfg_d;
         pa_q    <= pa_d;
         state_q <= state_d;
         k_q     <= k_d;
         a_q     <= a_d;
         acc_q   <= acc_d;
         m_q     <= m_d;
         fault_q <= fault_d;
         hit_q   <= hit_d;
         ent_q   <= ent_d;
      end
   end

   assign chk_ready = (state_q == IDLE);
   assign res_valid = (state_q == DONE);
   assign res_fault = fault_q;
   assign res_hit   = hit_q;
   assign res_entry = ent_q;
endmodule

// File: tb/tb_pmp_checker.sv
// tb_pmp_checker: directed tests for pmp_checker (8 entries).
// Covers CSR map, TOR/lock/restart/reset and the NAPOT build option.
module tb_pmp_checker;
   import pmp_pkg::*;

   localparam int N  = 8;
   localparam int IW = 3;
   localparam logic [2:0] R = 3'b001;
   localparam logic [2:0] W = 3'b010;
   localparam logic [1:0] PU = 2'b00;
   localparam logic [1:0] PM = 2'b11;

   logic          clk = 1'b0;
   logic          rst;
   logic [11:0]   addr;
   logic          wr;
   write_mode_t   write_mode;
   logic [31:0]   din;
   logic [31:0]   dout;
   logic          illegal_address;
   logic          chk_valid;
   logic          chk_ready;
   logic [31:0]   chk_addr;
   logic [2:0]    chk_acc;
   logic [1:0]    chk_priv;
   logic          res_valid;
   logic          res_fault;
   logic          res_hit;
   logic [IW-1:0] res_entry;

   int n_tests = 0;
   int n_fail  = 0;

   pmp_checker #(.NUM_ENTRIES(N)) dut (
      .clk(clk), .rst(rst), .addr(addr), .wr(wr),
      .write_mode(write_mode), .din(din), .dout(dout),
      .illegal_address(illegal_address),
      .chk_valid(chk_valid), .chk_ready(chk_ready),
      .chk_addr(chk_addr), .chk_acc(chk_acc), .chk_priv(chk_priv),
      .res_valid(res_valid), .res_fault(res_fault),
      .res_hit(res_hit), .res_entry(res_entry)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst = 1'b0; wr = 1'b0; addr = '0; din = '0;
      write_mode = CSR_WRITE; chk_valid = 1'b0;
      chk_addr = '0; chk_acc = '0; chk_priv = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic csr_wr(input logic [11:0] a, input write_mode_t m,
                         input logic [31:0] d);
      addr = a; write_mode = m; din = d; wr = 1'b1;
      @(posedge clk);
      #1 wr = 1'b0;
   endtask

   task automatic csr_rd(input logic [11:0] a, output logic [31:0] d,
                         output logic il);
      addr = a; wr = 1'b0;
      #2;
      d = dout; il = illegal_address;
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [2:0] acc,
                        input logic [1:0] pv);
      int w;
      w = 0;
      while (!chk_ready && w < 20) begin
         @(posedge clk);
         #1 w++;
      end
      chk_addr = a; chk_acc = acc; chk_priv = pv; chk_valid = 1'b1;
      @(posedge clk);
      #1 chk_valid = 1'b0;
   endtask

   task automatic wait_res(input int start, output int lat, output logic f,
                           output logic h, output logic [IW-1:0] e);
      lat = -1; f = 1'b0; h = 1'b0; e = '0;
      for (int c = start; c < start + 40; c++) begin
         if (res_valid) begin
            lat = c; f = res_fault; h = res_hit; e = res_entry;
            break;
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic il;
      do_reset();
      n_tests++;
      if (chk_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", chk_ready); end
      n_tests++;
      if ({res_valid, res_fault, res_hit, res_entry} !== '0) begin
         n_fail++; $display("FAIL rst_res got %b%b%b %0d exp 0", res_valid, res_fault, res_hit, res_entry);
      end
      csr_rd(12'h3A0, d, il);
      n_tests++;
      if (d !== 32'h0 || il !== 1'b0) begin n_fail++; $display("FAIL rst_cfg0 got %h/%b exp 0/0", d, il); end
      for (int i = 0; i < N; i++) begin
         csr_rd(12'h3B0 + 12'(i), d, il);
         n_tests++;
         if (d !== 32'h0 || il !== 1'b0) begin n_fail++; $display("FAIL rst_addr%0d got %h/%b exp 0/0", i, d, il); end
      end
      csr_rd(12'h3C5, d, il);
      n_tests++;
      if (d !== 32'h0 || il !== 1'b1) begin n_fail++; $display("FAIL ill_3C5 got %h/%b exp 0/1", d, il); end
      csr_rd(12'h3A2, d, il);
      n_tests++;
      if (il !== 1'b1) begin n_fail++; $display("FAIL ill_3A2 got %b exp 1", il); end
      csr_rd(12'h3B8, d, il);
      n_tests++;
      if (il !== 1'b1) begin n_fail++; $display("FAIL ill_3B8 got %b exp 1", il); end
   endtask

   task automatic test_csr();
      logic [31:0] d;
      logic il;
      do_reset();
      csr_wr(12'h3B1, CSR_WRITE, 32'hDEADBEEF);
      csr_rd(12'h3B1, d, il);
      n_tests++;
      if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pa_write got %h exp DEADBEEF", d); end
      csr_wr(12'h3B1, CSR_SET, 32'h000000F0);
      csr_rd(12'h3B1, d, il);
      n_tests++;
      if (d !== 32'hDEADBEFF) begin n_fail++; $display("FAIL pa_set got %h exp DEADBEFF", d); end
      csr_wr(12'h3B1, CSR_CLEAR, 32'hDEAD0000);
      csr_rd(12'h3B1, d, il);
      n_tests++;
      if (d !== 32'h0000BEFF) begin n_fail++; $display("FAIL pa_clear got %h exp 0000BEFF", d); end
      csr_wr(12'h3C5, CSR_WRITE, 32'h12345678);
      csr_rd(12'h3B1, d, il);
      n_tests++;
      if (d !== 32'h0000BEFF) begin n_fail++; $display("FAIL ill_wr got %h exp 0000BEFF", d); end
      csr_wr(12'h3A1, CSR_WRITE, 32'h66090A6B);
      csr_rd(12'h3A1, d, il);
      n_tests++;
      if (d !== 32'h0409080B) begin n_fail++; $display("FAIL cfg_legal got %h exp 0409080B", d); end
      csr_wr(12'h3A1, CSR_CLEAR, 32'h00000001);
      csr_rd(12'h3A1, d, il);
      n_tests++;
      if (d !== 32'h04090808) begin n_fail++; $display("FAIL cfg_clear got %h exp 04090808", d); end
   endtask

   task automatic test_tor();
      int lat;
      logic f, h;
      logic [IW-1:0] e;
      do_reset();
      csr_wr(12'h3B0, CSR_WRITE, 32'h400);
      csr_wr(12'h3A0, CSR_WRITE, 32'h09);
      issue(32'h0FFC, R, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 2 || h !== 1'b1 || e !== 3'd0 || f !== 1'b0) begin
         n_fail++; $display("FAIL tor_load got lat%0d h%b e%0d f%b exp lat2 h1 e0 f0", lat, h, e, f);
      end
      issue(32'h0FFC, W, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 2 || h !== 1'b1 || f !== 1'b1) begin
         n_fail++; $display("FAIL tor_store got lat%0d h%b f%b exp lat2 h1 f1", lat, h, f);
      end
      issue(32'h0FFC, W, PM);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 2 || h !== 1'b1 || f !== 1'b0) begin
         n_fail++; $display("FAIL tor_m_exempt got lat%0d h%b f%b exp lat2 h1 f0", lat, h, f);
      end
      issue(32'h1000, R, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 9 || h !== 1'b0 || e !== 3'd0 || f !== 1'b1) begin
         n_fail++; $display("FAIL nomatch_u got lat%0d h%b e%0d f%b exp lat9 h0 e0 f1", lat, h, e, f);
      end
      issue(32'h1000, R, PM);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 9 || h !== 1'b0 || f !== 1'b0) begin
         n_fail++; $display("FAIL nomatch_m got lat%0d h%b f%b exp lat9 h0 f0", lat, h, f);
      end
      csr_wr(12'h3B1, CSR_WRITE, 32'h800);
      csr_wr(12'h3A0, CSR_WRITE, 32'h0B09);
      issue(32'h1000, W, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 3 || h !== 1'b1 || e !== 3'd1 || f !== 1'b0) begin
         n_fail++; $display("FAIL tor_e1 got lat%0d h%b e%0d f%b exp lat3 h1 e1 f0", lat, h, e, f);
      end
      issue(32'h0FFC, R, PU);
      chk_valid = 1'b1; chk_addr = 32'h1000; chk_acc = W;
      n_tests++;
      if (chk_ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b exp 0", chk_ready); end
      wait_res(1, lat, f, h, e);
      chk_valid = 1'b0;
      n_tests++;
      if (lat !== 2 || h !== 1'b1 || e !== 3'd0 || f !== 1'b0) begin
         n_fail++; $display("FAIL busy_latch got lat%0d h%b e%0d f%b exp lat2 h1 e0 f0", lat, h, e, f);
      end
   endtask

   task automatic test_lock();
      int lat;
      logic f, h, il;
      logic [IW-1:0] e;
      logic [31:0] d;
      do_reset();
      csr_wr(12'h3B0, CSR_WRITE, 32'h400);
      csr_wr(12'h3A0, CSR_WRITE, 32'h00880088);
      issue(32'h0, R, PM);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 2 || h !== 1'b1 || f !== 1'b1) begin
         n_fail++; $display("FAIL lock_m got lat%0d h%b f%b exp lat2 h1 f1", lat, h, f);
      end
      csr_wr(12'h3B0, CSR_WRITE, 32'h123);
      csr_rd(12'h3B0, d, il);
      n_tests++;
      if (d !== 32'h400) begin n_fail++; $display("FAIL lock_pa0 got %h exp 400", d); end
      csr_wr(12'h3A0, CSR_CLEAR, 32'hFF);
      csr_rd(12'h3A0, d, il);
      n_tests++;
      if (d !== 32'h00880088) begin n_fail++; $display("FAIL lock_cfg got %h exp 00880088", d); end
      csr_wr(12'h3B1, CSR_WRITE, 32'h55);
      csr_rd(12'h3B1, d, il);
      n_tests++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL lock_tor_prev got %h exp 0", d); end
      csr_wr(12'h3B3, CSR_WRITE, 32'h77);
      csr_rd(12'h3B3, d, il);
      n_tests++;
      if (d !== 32'h77) begin n_fail++; $display("FAIL unlocked_pa3 got %h exp 77", d); end
   endtask

   task automatic test_restart();
      int lat;
      logic f, h;
      logic [IW-1:0] e;
      logic seen;
      do_reset();
      csr_wr(12'h3B0, CSR_WRITE, 32'h10);
      csr_wr(12'h3A0, CSR_WRITE, 32'h09);
      issue(32'h0FFC, R, PU);
      @(posedge clk);
      #1;
      csr_wr(12'h3B0, CSR_WRITE, 32'h400);
      wait_res(3, lat, f, h, e);
      n_tests++;
      if (lat !== 4 || h !== 1'b1 || e !== 3'd0 || f !== 1'b0) begin
         n_fail++; $display("FAIL restart got lat%0d h%b e%0d f%b exp lat4 h1 e0 f0", lat, h, e, f);
      end
      @(posedge clk);
      #1;
      chk_addr = 32'h0FFC; chk_acc = R; chk_priv = PU; chk_valid = 1'b1;
      csr_wr(12'h3B0, CSR_WRITE, 32'h10);
      chk_valid = 1'b0;
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 9 || h !== 1'b0 || f !== 1'b1) begin
         n_fail++; $display("FAIL accept_wr got lat%0d h%b f%b exp lat9 h0 f1", lat, h, f);
      end
      issue(32'h1000, R, PU);
      @(posedge clk);
      #1 rst = 1'b0;
      #2;
      n_tests++;
      if (chk_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_state got rdy%b v%b exp rdy1 v0", chk_ready, res_valid);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         seen |= res_valid;
         @(posedge clk);
         #1;
      end
      n_tests++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b exp 0", seen); end
   endtask

`ifdef PMP_NAPOT_EN
   task automatic test_napot();
      int lat;
      logic f, h, il;
      logic [IW-1:0] e;
      logic [31:0] d;
      do_reset();
      csr_wr(12'h3B3, CSR_WRITE, 32'h1FF);
      csr_wr(12'h3A0, CSR_WRITE, 32'h1B000000);
      csr_rd(12'h3A0, d, il);
      n_tests++;
      if (d !== 32'h1B000000) begin n_fail++; $display("FAIL napot_cfg got %h exp 1B000000", d); end
      issue(32'h07F0, W, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 5 || h !== 1'b1 || e !== 3'd3 || f !== 1'b0) begin
         n_fail++; $display("FAIL napot_hit got lat%0d h%b e%0d f%b exp lat5 h1 e3 f0", lat, h, e, f);
      end
      issue(32'h1000, W, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 9 || h !== 1'b0 || f !== 1'b1) begin
         n_fail++; $display("FAIL napot_out got lat%0d h%b f%b exp lat9 h0 f1", lat, h, f);
      end
      csr_wr(12'h3B2, CSR_WRITE, 32'h404);
      csr_wr(12'h3A0, CSR_WRITE, 32'h1B130000);
      issue(32'h1010, R, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 4 || h !== 1'b1 || e !== 3'd2 || f !== 1'b0) begin
         n_fail++; $display("FAIL na4_hit got lat%0d h%b e%0d f%b exp lat4 h1 e2 f0", lat, h, e, f);
      end
   endtask
`else
   task automatic test_no_napot();
      int lat;
      logic f, h, il;
      logic [IW-1:0] e;
      logic [31:0] d;
      do_reset();
      csr_wr(12'h3B3, CSR_WRITE, 32'h1FF);
      csr_wr(12'h3A0, CSR_WRITE, 32'h1F1F1F1F);
      csr_rd(12'h3A0, d, il);
      n_tests++;
      if (d !== 32'h07070707) begin n_fail++; $display("FAIL nonapot_cfg got %h exp 07070707", d); end
      csr_wr(12'h3A1, CSR_WRITE, 32'h00000013);
      csr_rd(12'h3A1, d, il);
      n_tests++;
      if (d !== 32'h00000003) begin n_fail++; $display("FAIL nona4_cfg got %h exp 00000003", d); end
      issue(32'h07F0, R, PU);
      wait_res(1, lat, f, h, e);
      n_tests++;
      if (lat !== 9 || h !== 1'b0 || e !== 3'd0 || f !== 1'b1) begin
         n_fail++; $display("FAIL nonapot_chk got lat%0d h%b e%0d f%b exp lat9 h0 e0 f1", lat, h, e, f);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_csr();
      test_tor();
      test_lock();
      test_restart();
`ifdef PMP_NAPOT_EN
      test_napot();
`else
      test_no_napot();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
